data_sram_bridge: RTL and testbench

DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

---
 rtl/data_sram_bridge.sv | 143 ++++++++++++++
 tb/tb_data_sram_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// Bridge between the MEM stage and an sram-like data port.
// One access in flight at a time. Requests and the pipeline stall are combinational
// so that a request launches in the same cycle the access appears. The request
// fields are latched so they stay constant while addr_ok is awaited. Load data is
// registered on data_ok.
module data_sram_bridge (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_en,
   input  logic        i_wr,
   input  logic [1:0]  i_size,
   input  logic [3:0]  i_wstrb,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_advance,
   output logic [31:0] o_rdata,
   output logic        o_stallreq,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        wr_q, wr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        valid_s;
   logic        req_s;
   logic        stall_s;

   // A store with no byte enabled is a no-op and must not touch the bus.
   assign valid_s = i_en && (!i_wr || (i_wstrb != 4'd0));

   // Next-state, hold-register and bus/stall output decode.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      wr_d       = wr_q;
      rdata_d    = rdata_q;
      req_s      = 1'b0;
      stall_s    = 1'b0;
      data_addr  = addr_q;
      data_wdata = wdata_q;
      data_size  = size_q;
      data_wr    = wr_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_s) begin
               req_s      = 1'b1;
               stall_s    = 1'b1;
               data_addr  = i_addr;
               data_wdata = i_wdata;
               data_size  = i_size;
               data_wr    = i_wr;
               addr_d     = i_addr;
               wdata_d    = i_wdata;
               size_d     = i_size;
               wr_d       = i_wr;
               if (data_addr_ok) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_REQ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            req_s   = 1'b1;
            stall_s = 1'b1;
            if (data_addr_ok) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            stall_s = 1'b1;
            if (data_data_ok) begin
               state_d = ST_DONE;
               if (!wr_q) begin
                  rdata_d = data_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (i_advance) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request and stall are forced low while reset is held, even with a valid access present.
   assign data_req   = req_s & reset;
   assign o_stallreq = stall_s & reset;
   assign o_rdata    = rdata_q;

   // State, request hold registers and load data register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         size_q  <= 2'd0;
         wr_q    <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge. The bench plays the sram slave with
// chosen addr_ok/data_ok delays and predicts, per transaction, how many cycles
// request and stall must be high, the field values, and the resulting o_rdata.
module tb_data_sram_bridge;

   logic        clk;
   logic        reset;
   logic        i_en;
   logic        i_wr;
   logic [1:0]  i_size;
   logic [3:0]  i_wstrb;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        i_advance;
   logic [31:0] o_rdata;
   logic        o_stallreq;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   int          n_cmp;
   int          n_bad;
   logic [31:0] exp_rdata;
   int          req_cnt;
   logic        stall_tr[$];

   data_sram_bridge dut (
      .clk          (clk),
      .reset        (reset),
      .i_en         (i_en),
      .i_wr         (i_wr),
      .i_size       (i_size),
      .i_wstrb      (i_wstrb),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .i_advance    (i_advance),
      .o_rdata      (o_rdata),
      .o_stallreq   (o_stallreq),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // Randomise the MEM-stage inputs that must not matter after launch.
   task automatic noise_inputs();
      i_en    = 1'($urandom_range(0, 1));
      i_wr    = 1'($urandom_range(0, 1));
      i_size  = 2'($urandom_range(0, 3));
      i_wstrb = 4'($urandom_range(0, 15));
      i_addr  = $urandom;
      i_wdata = $urandom;
   endtask

   // One full access: launch, a_dly cycles without addr_ok, d_dly wait cycles, adv_dly DONE cycles.
   // Called at a negedge; returns at a negedge with the DUT back in idle.
   task automatic run_txn(input logic wr, input logic [1:0] size, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int a_dly, input int d_dly, input logic [31:0] rvalue,
                          input int adv_dly);
      req_cnt = 0;
      stall_tr.delete();
      for (int k = 0; k <= a_dly; k++) begin
         if (k == 0) begin
            i_en = 1'b1; i_wr = wr; i_size = size; i_wstrb = strb; i_addr = addr; i_wdata = wdata;
         end else begin
            noise_inputs();
         end
         i_advance    = 1'b0;
         data_addr_ok = (k == a_dly);
         data_data_ok = 1'($urandom_range(0, 1));
         data_rdata   = $urandom;
         #1;
         stall_tr.push_back(o_stallreq);
         if (data_req === 1'b1) req_cnt++;
         n_cmp++; if (data_req !== 1'b1) begin n_bad++; $display("FAIL req_phase_req: got %b want 1 (k=%0d)", data_req, k); end
         n_cmp++; if (o_stallreq !== 1'b1) begin n_bad++; $display("FAIL req_phase_stall: got %b want 1 (k=%0d)", o_stallreq, k); end
         n_cmp++; if (data_addr !== addr) begin n_bad++; $display("FAIL req_addr: got %h want %h", data_addr, addr); end
         n_cmp++; if (data_wdata !== wdata) begin n_bad++; $display("FAIL req_wdata: got %h want %h", data_wdata, wdata); end
         n_cmp++; if (data_size !== size) begin n_bad++; $display("FAIL req_size: got %0d want %0d", data_size, size); end
         n_cmp++; if (data_wr !== wr) begin n_bad++; $display("FAIL req_wr: got %b want %b", data_wr, wr); end
         n_cmp++; if (o_rdata !== exp_rdata) begin n_bad++; $display("FAIL req_rdata: got %h want %h", o_rdata, exp_rdata); end
         @(negedge clk);
      end
      for (int j = 0; j <= d_dly; j++) begin
         noise_inputs();
         i_advance    = 1'($urandom_range(0, 1));
         data_addr_ok = 1'($urandom_range(0, 1));
         data_data_ok = (j == d_dly);
         data_rdata   = (j == d_dly) ? rvalue : $urandom;
         #1;
         stall_tr.push_back(o_stallreq);
         if (data_req === 1'b1) req_cnt++;
         n_cmp++; if (data_req !== 1'b0) begin n_bad++; $display("FAIL wait_req: got %b want 0", data_req); end
         n_cmp++; if (o_stallreq !== 1'b1) begin n_bad++; $display("FAIL wait_stall: got %b want 1", o_stallreq); end
         n_cmp++; if (o_rdata !== exp_rdata) begin n_bad++; $display("FAIL wait_rdata: got %h want %h", o_rdata, exp_rdata); end
         @(negedge clk);
      end
      if (!wr) exp_rdata = rvalue;
      for (int m = 0; m <= adv_dly; m++) begin
         noise_inputs();
         i_advance    = (m == adv_dly);
         data_addr_ok = 1'($urandom_range(0, 1));
         data_data_ok = 1'($urandom_range(0, 1));
         data_rdata   = $urandom;
         #1;
         stall_tr.push_back(o_stallreq);
         if (data_req === 1'b1) req_cnt++;
         n_cmp++; if (data_req !== 1'b0) begin n_bad++; $display("FAIL done_req: got %b want 0", data_req); end
         n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL done_stall: got %b want 0", o_stallreq); end
         n_cmp++; if (o_rdata !== exp_rdata) begin n_bad++; $display("FAIL done_rdata: got %h want %h", o_rdata, exp_rdata); end
         @(negedge clk);
      end
      i_en = 1'b0; i_advance = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
   endtask

   // Reset values, request suppression during reset, launch in the first cycle after release.
   task automatic test_reset();
      reset = 1'b0; i_en = 1'b1; i_wr = 1'b0; i_size = 2'd2; i_wstrb = 4'hF;
      i_addr = 32'h100; i_wdata = 32'd0; i_advance = 1'b0;
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
      exp_rdata = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (data_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", data_req); end
      n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", o_stallreq); end
      n_cmp++; if (o_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", o_rdata); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Load with addr_ok at launch and data_ok next cycle: stall 1,1,0.
   task automatic test_min_latency();
      run_txn(1'b0, 2'd2, 4'hF, 32'h0000_0100, 32'd0, 0, 0, 32'hDEAD_BEEF, 0);
      n_cmp++; if (stall_tr.size() != 3) begin n_bad++; $display("FAIL minlat_len: got %0d want 3", stall_tr.size()); end
      else begin
         n_cmp++; if ({stall_tr[0], stall_tr[1], stall_tr[2]} !== 3'b110) begin n_bad++;
            $display("FAIL minlat_stall: got %b%b%b want 110", stall_tr[0], stall_tr[1], stall_tr[2]); end
      end
      n_cmp++; if (o_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL minlat_rdata: got %h want deadbeef", o_rdata); end
   endtask

   // Store with addr_ok held off three cycles: four request cycles, o_rdata untouched.
   task automatic test_store_delayed();
      run_txn(1'b1, 2'd2, 4'hF, 32'h8000_1000, 32'h1234_5678, 3, 1, 32'h5555_AAAA, 0);
      n_cmp++; if (req_cnt != 4) begin n_bad++; $display("FAIL store_reqcnt: got %0d want 4", req_cnt); end
      n_cmp++; if (o_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL store_rdata: got %h want deadbeef", o_rdata); end
   endtask

   // Load completes while the pipeline does not advance for two cycles.
   task automatic test_done_hold();
      int zeros;
      run_txn(1'b0, 2'd1, 4'h3, 32'h0000_2002, 32'd0, 0, 0, 32'hCAFE_F00D, 2);
      zeros = 0;
      foreach (stall_tr[i]) if (stall_tr[i] === 1'b0) zeros++;
      n_cmp++; if (zeros != 3) begin n_bad++; $display("FAIL hold_zero_stalls: got %0d want 3", zeros); end
      run_txn(1'b0, 2'd0, 4'h1, 32'h0000_2003, 32'd0, 0, 0, 32'h0000_00A5, 0);
      n_cmp++; if (req_cnt != 1) begin n_bad++; $display("FAIL hold_relaunch: got %0d want 1", req_cnt); end
   endtask

   // Zero-strobe store and disabled access: no request, no stall.
   task automatic test_zero_strobe();
      for (int c = 0; c < 6; c++) begin
         i_en = (c < 4); i_wr = (c < 4) ? 1'b1 : 1'b0; i_wstrb = (c < 4) ? 4'h0 : 4'hF;
         i_addr = $urandom; i_wdata = $urandom; i_size = 2'd2;
         data_addr_ok = 1'($urandom_range(0, 1)); data_data_ok = 1'($urandom_range(0, 1));
         if (c >= 4) i_en = 1'b0;
         #1;
         n_cmp++; if (data_req !== 1'b0) begin n_bad++; $display("FAIL zstrb_req: got %b want 0 (c=%0d)", data_req, c); end
         n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL zstrb_stall: got %b want 0 (c=%0d)", o_stallreq, c); end
         @(negedge clk);
      end
      i_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
   endtask

   // Reset while waiting for data; the stray data_ok afterwards is ignored.
   task automatic test_reset_mid();
      i_en = 1'b1; i_wr = 1'b0; i_size = 2'd2; i_wstrb = 4'hF; i_addr = 32'h300; i_advance = 1'b0;
      data_addr_ok = 1'b1; data_data_ok = 1'b0;
      #1;
      n_cmp++; if (data_req !== 1'b1) begin n_bad++; $display("FAIL rmid_launch: got %b want 1", data_req); end
      @(negedge clk);
      i_en = 1'b0; data_addr_ok = 1'b0;
      reset = 1'b0;
      exp_rdata = 32'd0;
      #1;
      n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL rmid_stall: got %b want 0", o_stallreq); end
      n_cmp++; if (o_rdata !== 32'd0) begin n_bad++; $display("FAIL rmid_rdata: got %h want 0", o_rdata); end
      @(negedge clk);
      reset = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h7777_1111;
      #1;
      n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL rmid_okstall: got %b want 0", o_stallreq); end
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      n_cmp++; if (o_rdata !== 32'd0) begin n_bad++; $display("FAIL rmid_ignored: got %h want 0", o_rdata); end
      n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL rmid_idle: got %b want 0", o_stallreq); end
      @(negedge clk);
   endtask

   // Two loads 0x0 then 0x4 with no gap between them.
   task automatic test_back_to_back();
      run_txn(1'b0, 2'd2, 4'hF, 32'h0000_0000, 32'd0, 1, 0, 32'h0102_0304, 0);
      n_cmp++; if (req_cnt != 2) begin n_bad++; $display("FAIL b2b_first_reqcnt: got %0d want 2", req_cnt); end
      n_cmp++; if (o_rdata !== 32'h0102_0304) begin n_bad++; $display("FAIL b2b_first_rdata: got %h want 01020304", o_rdata); end
      run_txn(1'b0, 2'd2, 4'hF, 32'h0000_0004, 32'd0, 0, 2, 32'hA0B0_C0D0, 0);
      n_cmp++; if (req_cnt != 1) begin n_bad++; $display("FAIL b2b_second_reqcnt: got %0d want 1", req_cnt); end
      n_cmp++; if (o_rdata !== 32'hA0B0_C0D0) begin n_bad++; $display("FAIL b2b_second_rdata: got %h want a0b0c0d0", o_rdata); end
   endtask

   // Random mix of loads and stores with random slave delays and idle gaps.
   task automatic test_random();
      logic        wr;
      logic [3:0]  strb;
      int          a_dly;
      int          gap;
      for (int t = 0; t < 40; t++) begin
         wr    = 1'($urandom_range(0, 1));
         strb  = wr ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
         a_dly = $urandom_range(0, 3);
         run_txn(wr, 2'($urandom_range(0, 2)), strb, $urandom, $urandom,
                 a_dly, $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
         n_cmp++; if (req_cnt != a_dly + 1) begin n_bad++; $display("FAIL rnd_reqcnt: got %0d want %0d", req_cnt, a_dly + 1); end
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            i_en = 1'b0; data_data_ok = 1'($urandom_range(0, 1)); data_addr_ok = 1'($urandom_range(0, 1));
            #1;
            n_cmp++; if (o_stallreq !== 1'b0) begin n_bad++; $display("FAIL rnd_gap_stall: got %b want 0", o_stallreq); end
            n_cmp++; if (o_rdata !== exp_rdata) begin n_bad++; $display("FAIL rnd_gap_rdata: got %h want %h", o_rdata, exp_rdata); end
            @(negedge clk);
         end
         data_data_ok = 1'b0; data_addr_ok = 1'b0;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_min_latency();
      test_store_delayed();
      test_done_hold();
      test_zero_strobe();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
